// File: rtl/sar_adc_ctrl_if.sv
// Control/result handshake of the SAR conversion controller.
// The requester drives start/abort; the controller returns busy/done/result.
interface sar_adc_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives trial codes to an external R-2R DAC and
// resolves one bit per trial from a synchronized comparator decision.
module sar_adc_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter bit          CMP_INVERT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             sample_hold,
    sar_adc_ctrl_if.slave    bus
);
    localparam int unsigned CntMax = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES
                                                                     : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StSample, StSettle, StDecide, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  dac_q, dac_d;
    logic              sh_q, sh_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [1:0]        sync_q;
    logic              cmp_s;
    logic [WIDTH-1:0]  bit_mask;
    logic [WIDTH-1:0]  kept;

    // cmp_s = 1 means Vin >= Vdac regardless of comparator polarity.
    assign cmp_s    = sync_q[1] ^ CMP_INVERT;
    assign bit_mask = WIDTH'(1) << bit_q;
    assign kept     = cmp_s ? (work_q | bit_mask) : work_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        work_d   = work_q;
        dac_d    = dac_q;
        sh_d     = sh_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                dac_d  = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = StSample;
                    busy_d  = 1'b1;
                    sh_d    = 1'b1;
                    cnt_d   = '0;
                    work_d  = '0;
                    bit_d   = IdxW'(WIDTH - 1);
                end
            end
            StSample: begin
                if (cnt_q == CntW'(SAMPLE_CYCLES - 1)) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                    sh_d    = 1'b0;
                    dac_d   = work_q | bit_mask;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSettle: begin
                if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                    state_d = StDecide;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDecide: begin
                work_d = kept;
                if (bit_q != '0) begin
                    bit_d   = bit_q - IdxW'(1);
                    dac_d   = kept | (bit_mask >> 1);
                    state_d = StSettle;
                end else begin
                    dac_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d = work_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                dac_d    = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides every transition, including the DONE result update.
        if (bus.abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            dac_d    = '0;
            sh_d     = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            work_q   <= '0;
            dac_q    <= '0;
            sh_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            work_q   <= work_d;
            dac_q    <= dac_d;
            sh_q     <= sh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            sync_q   <= {sync_q[0], cmp_in};
        end
    end

    assign dac_code    = dac_q;
    assign sample_hold = sh_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller that closes the loop around an on-chip opamp used as a comparator. It drives a binary trial code to an off-chip R-2R DAC on the dedicated outputs and reads the comparator decision back on a dedicated input. It emits one WIDTH-bit conversion result per start request. It sits in the digital half of an analog tile, beside the opamp and bias macros.

Parameters:
WIDTH, 8, conversion resolution in bits (2..12)
SAMPLE_CYCLES, 4, cycles sample_hold is held high before the first trial (>=1)
SETTLE_CYCLES, 4, wait cycles per trial before the comparator is sampled (>=2, covers the synchronizer)
CMP_INVERT, 0, 1 = comparator output is active-low (Vin >= Vdac reads as 0)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle conversion request
abort  in  1  cancel the conversion in progress
cmp_in  in  1  asynchronous comparator output from the analog pin
dac_code  out  WIDTH  trial code to the external DAC
sample_hold  out  1  high during the sample phase
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when result updates
result  out  WIDTH  last completed conversion

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: dac_code=0, sample_hold=0, busy=0, done=0, result=0, state=IDLE, synchronizer flops=0.
- cmp_in passes through a 2-flop synchronizer. cmp_s = sync output XOR CMP_INVERT. cmp_s=1 means Vin >= Vdac.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE. A bit index counts from WIDTH-1 down to 0. A cycle counter is sized for max(SAMPLE_CYCLES, SETTLE_CYCLES).
- IDLE: dac_code=0, busy=0. If start=1 at the edge, go to SAMPLE: busy=1, sample_hold=1, counter=0, working code=0, bit=WIDTH-1.
- SAMPLE: lasts exactly SAMPLE_CYCLES cycles. On exit, go to SETTLE: sample_hold=0, dac_code = working | (1<<bit).
- SETTLE: lasts exactly SETTLE_CYCLES cycles with dac_code stable, then go to DECIDE.
- DECIDE (1 cycle): if cmp_s=1, keep the bit; otherwise clear it. Update working and dac_code accordingly.
  - If bit>0: decrement bit, set dac_code = updated working | (1<<(bit-1)), go to SETTLE.
  - If bit==0: go to DONE.
- DONE (1 cycle): result=working, done=1, busy=0, dac_code=0. Next state is always IDLE.
- Latency: done is high in the cycle following edge 1+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+1), counted from the edge that sampled start. With defaults this is 45.
- busy spans exactly from the edge after start to the edge that enters DONE.
- start outside IDLE (including DONE) is ignored. It is neither queued nor allowed to disturb the conversion.
- abort=1 in any non-IDLE state: next state IDLE, dac_code=0, sample_hold=0, busy=0. No done pulse; result is unchanged. abort has priority over all transitions. abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
- rst mid-conversion: immediate return to reset values at the next edge, and result is cleared. rst has priority over abort and start.
- Arithmetic is unsigned with no carries; bits are only set or cleared, never added.

Test Plan:
- Behavioural comparator model cmp_in = (vin_code >= dac_code), defaults, vin_code=0xA5, one start pulse -> trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; result=0xA5; done 1-cycle pulse exactly 45 edges after start; busy high for 44 cycles.
- Endpoints: vin_code=0x00 -> result 0x00; vin_code=0xFF -> result 0xFF; the 0xFF run is followed immediately by a start for 0x3C -> result 0x3C; sample_hold high exactly 4 cycles per conversion.
- start pulses at cycles 10 and 30 of an active conversion (vin_code=0x5A) -> ignored; single done; result 0x5A; total latency still 45.
- abort at cycle 20 (vin_code=0x77, previous result 0x12) -> busy low and dac_code=0 the next cycle; no done; result stays 0x12. A following conversion -> 0x77.
- rst asserted at cycle 25 of a conversion -> all outputs at reset values the next cycle; result=0. A new start afterwards converts correctly.
- CMP_INVERT=1, WIDTH=4, SETTLE_CYCLES=2, inverted model with vin_code=0x9 -> result 0x9; done at edge 1+4+4*3=17.
